// File: rtl/unidade_controle_rodadas.sv
// Round-based control unit for the memory game: grows the sequence by one
// play per round, tracks the round index, and optionally times out idle plays.

package unidade_controle_rodadas_pkg;
  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicia_rodada  = 4'h2,
    espera_jogada  = 4'h3,
    registra       = 4'h4,
    comparacao     = 4'h5,
    proximo        = 4'h6,
    proxima_rodada = 4'h7,
    final_acerto   = 4'hA,
    final_timeout  = 4'hD,
    final_erro     = 4'hE
  } estado_t;
endpackage

module unidade_controle_rodadas
  import unidade_controle_rodadas_pkg::*;
#(
  parameter int unsigned N_RODADAS      = 16,
  parameter int unsigned W_RODADA       = 4,
  parameter int unsigned TIMEOUT_CICLOS = 5000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                jogada,
  input  logic                igual,
  input  logic                enderecoIgualRodada,
  input  logic                timeout_en,
  output logic                zeraE,
  output logic                contaE,
  output logic                zeraR,
  output logic                registraR,
  output logic [W_RODADA-1:0] rodada,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic                pronto,
  output logic [3:0]          db_estado
);

  localparam int unsigned W_TIMER = $clog2(TIMEOUT_CICLOS);
  localparam logic [W_TIMER-1:0]  TIMER_LIMITE  = W_TIMER'(TIMEOUT_CICLOS - 1);
  localparam logic [W_RODADA-1:0] ULTIMA_RODADA = W_RODADA'(N_RODADAS - 1);

  estado_t            estado;
  estado_t            proximo_estado;
  logic [W_TIMER-1:0] timer;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= inicial;
    end else begin
      estado <= proximo_estado;
    end
  end

  // Round counter and per-play timer, both driven by the current state
  always_ff @(posedge clock) begin
    if (reset) begin
      rodada <= '0;
      timer  <= '0;
    end else begin
      case (estado)
        preparacao: begin
          rodada <= '0;
          timer  <= '0;
        end
        inicia_rodada, proximo: timer <= '0;
        espera_jogada: begin
          // saturating count; held while the timeout is disabled
          if (timeout_en && (timer != '1)) timer <= timer + 1'b1;
        end
        proxima_rodada: begin
          if (rodada != ULTIMA_RODADA) rodada <= rodada + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    proximo_estado = inicial;
    zeraE          = 1'b0;
    contaE         = 1'b0;
    zeraR          = 1'b0;
    registraR      = 1'b0;
    acertou        = 1'b0;
    errou          = 1'b0;
    timeout        = 1'b0;
    pronto         = 1'b0;
    db_estado      = estado;
    case (estado)
      inicial: begin
        zeraE          = 1'b1;
        zeraR          = 1'b1;
        proximo_estado = iniciar ? preparacao : inicial;
      end
      preparacao: begin
        zeraE          = 1'b1;
        zeraR          = 1'b1;
        proximo_estado = inicia_rodada;
      end
      inicia_rodada: begin
        zeraE          = 1'b1;
        proximo_estado = espera_jogada;
      end
      espera_jogada: begin
        if (jogada) begin
          proximo_estado = registra;
        end else if (timeout_en && (timer == TIMER_LIMITE)) begin
          proximo_estado = final_timeout;
        end else begin
          proximo_estado = espera_jogada;
        end
      end
      registra: begin
        registraR      = 1'b1;
        proximo_estado = comparacao;
      end
      comparacao: begin
        if (!igual) begin
          proximo_estado = final_erro;
        end else if (!enderecoIgualRodada) begin
          proximo_estado = proximo;
        end else if (rodada == ULTIMA_RODADA) begin
          proximo_estado = final_acerto;
        end else begin
          proximo_estado = proxima_rodada;
        end
      end
      proximo: begin
        contaE         = 1'b1;
        proximo_estado = espera_jogada;
      end
      proxima_rodada: proximo_estado = inicia_rodada;
      final_acerto: begin
        acertou        = 1'b1;
        pronto         = 1'b1;
        proximo_estado = iniciar ? preparacao : final_acerto;
      end
      final_erro: begin
        errou          = 1'b1;
        pronto         = 1'b1;
        proximo_estado = iniciar ? preparacao : final_erro;
      end
      final_timeout: begin
        timeout        = 1'b1;
        pronto         = 1'b1;
        proximo_estado = iniciar ? preparacao : final_timeout;
      end
      default: begin
        db_estado      = 4'hF;
        proximo_estado = inicial;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas (4 rounds, 20-cycle timeout): a fixed
// vector table plus scenario sequences, with a cycle-level scoreboard.

module tb_unidade_controle_rodadas;

  localparam int NR  = 4;
  localparam int TO  = 20;
  localparam int TMX = (1 << $clog2(TO)) - 1;

  logic       clock = 1'b0;
  logic       rst = 1'b1, ini = 1'b0, jog = 1'b0, ig = 1'b0, eir = 1'b0, ten = 1'b0;
  logic       zeraE, contaE, zeraR, registraR, acertou, errou, timeout, pronto;
  logic [3:0] rodada;
  logic [3:0] db_estado;

  int total = 0;
  int bad = 0;
  int n_reg, n_ce, n;
  int m_st, m_rod, m_tmr;
  logic [15:0] sb_q[$];

  typedef struct packed {
    logic [4:0] in;   // rst, iniciar, jogada, igual, enderecoIgualRodada
    logic [3:0] db;
    logic [3:0] rod;
    logic [4:0] ctl;  // zeraE, contaE, zeraR, registraR, pronto
  } vec_t;
  vec_t vecs[$];

  unidade_controle_rodadas #(
    .N_RODADAS(NR),
    .W_RODADA(4),
    .TIMEOUT_CICLOS(TO)
  ) dut (
    .clock(clock),
    .reset(rst),
    .iniciar(ini),
    .jogada(jog),
    .igual(ig),
    .enderecoIgualRodada(eir),
    .timeout_en(ten),
    .zeraE(zeraE),
    .contaE(contaE),
    .zeraR(zeraR),
    .registraR(registraR),
    .rodada(rodada),
    .acertou(acertou),
    .errou(errou),
    .timeout(timeout),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_outs();
    logic ze, ce, zr, rr, ac, er, tm;
    ze = 0; ce = 0; zr = 0; rr = 0; ac = 0; er = 0; tm = 0;
    case (m_st)
      0, 1: begin ze = 1; zr = 1; end
      2: ze = 1;
      4: rr = 1;
      6: ce = 1;
      10: ac = 1;
      13: tm = 1;
      14: er = 1;
      default: ;
    endcase
    return {ze, ce, zr, rr, ac, er, tm, (ac | er | tm), 4'(m_rod), 4'(m_st)};
  endfunction

  task automatic m_advance(input logic r, input logic i, input logic j, input logic g, input logic e);
    int ns;
    if (r) begin
      m_st = 0; m_rod = 0; m_tmr = 0;
      return;
    end
    ns = m_st;
    case (m_st)
      0: if (i) ns = 1;
      1: begin ns = 2; m_rod = 0; m_tmr = 0; end
      2: begin ns = 3; m_tmr = 0; end
      3: begin
        if (j) ns = 4;
        else if (ten && m_tmr == TO - 1) ns = 13;
        if (ten && m_tmr < TMX) m_tmr++;
      end
      4: ns = 5;
      5: begin
        if (!g) ns = 14;
        else if (!e) ns = 6;
        else if (m_rod == NR - 1) ns = 10;
        else ns = 7;
      end
      6: begin ns = 3; m_tmr = 0; end
      7: begin ns = 2; m_rod++; end
      10, 13, 14: if (i) ns = 1;
      default: ns = 0;
    endcase
    m_st = ns;
  endtask

  // One clock: drive inputs, queue the expected result, compare after the edge.
  task automatic cycle(input logic i, input logic j, input logic g, input logic e);
    logic [15:0] exp;
    ini = i; jog = j; ig = g; eir = e;
    m_advance(rst, i, j, g, e);
    sb_q.push_back(m_outs());
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 16'h0, 16'h1);
    end else begin
      exp = sb_q.pop_front();
      check("cycle_outputs",
            {zeraE, contaE, zeraR, registraR, acertou, errou, timeout, pronto, rodada, db_estado},
            exp);
    end
    if (registraR) n_reg++;
    if (contaE) n_ce++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic settle();
    for (int k = 0; k < 6; k++) begin
      if (m_st == 3 || m_st == 10 || m_st == 13 || m_st == 14) break;
      cycle(0, 0, 0, 0);
    end
  endtask

  task automatic play(input logic g, input logic e);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, g, e);
  endtask

  task automatic start_game();
    cycle(1, 0, 0, 0);
    settle();
  endtask

  task automatic full_rounds(input int upto);
    for (int r = 0; r < upto; r++) begin
      check($sformatf("rodada_start_r%0d", r), 16'(rodada), 16'(r));
      for (int k = 0; k <= r; k++) begin
        play(1'b1, (k == r));
        settle();
      end
    end
  endtask

  task automatic count_to_timeout(input string nm);
    n = 0;
    while (db_estado == 4'h3 && n < 100) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    check(nm, 16'(n), 16'(TO));
  endtask

  initial begin
    m_st = 0; m_rod = 0; m_tmr = 0; n_reg = 0; n_ce = 0;

    vecs.push_back('{5'b10000, 4'h0, 4'd0, 5'b10100});
    vecs.push_back('{5'b01000, 4'h1, 4'd0, 5'b10100});
    vecs.push_back('{5'b00000, 4'h2, 4'd0, 5'b10000});
    vecs.push_back('{5'b00000, 4'h3, 4'd0, 5'b00000});
    vecs.push_back('{5'b01000, 4'h3, 4'd0, 5'b00000});
    vecs.push_back('{5'b00100, 4'h4, 4'd0, 5'b00010});
    vecs.push_back('{5'b00000, 4'h5, 4'd0, 5'b00000});
    vecs.push_back('{5'b00011, 4'h7, 4'd0, 5'b00000});
    vecs.push_back('{5'b00000, 4'h2, 4'd1, 5'b10000});
    vecs.push_back('{5'b00000, 4'h3, 4'd1, 5'b00000});
    vecs.push_back('{5'b00100, 4'h4, 4'd1, 5'b00010});
    vecs.push_back('{5'b00000, 4'h5, 4'd1, 5'b00000});
    vecs.push_back('{5'b00010, 4'h6, 4'd1, 5'b01000});
    vecs.push_back('{5'b00000, 4'h3, 4'd1, 5'b00000});
    vecs.push_back('{5'b00100, 4'h4, 4'd1, 5'b00010});
    vecs.push_back('{5'b00000, 4'h5, 4'd1, 5'b00000});
    vecs.push_back('{5'b00000, 4'hE, 4'd1, 5'b00001});
    vecs.push_back('{5'b00000, 4'hE, 4'd1, 5'b00001});
    vecs.push_back('{5'b01000, 4'h1, 4'd1, 5'b10100});
    vecs.push_back('{5'b00000, 4'h2, 4'd0, 5'b10000});

    foreach (vecs[i]) begin
      rst = vecs[i].in[4];
      cycle(vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
      check($sformatf("vec%0d_db", i), 16'(db_estado), 16'(vecs[i].db));
      check($sformatf("vec%0d_rodada", i), 16'(rodada), 16'(vecs[i].rod));
      check($sformatf("vec%0d_ctl", i), 16'({zeraE, contaE, zeraR, registraR, pronto}), 16'(vecs[i].ctl));
    end
    rst = 1'b0;

    // Complete game, all plays correct
    ten = 1'b0;
    reset_dut();
    n_reg = 0; n_ce = 0;
    start_game();
    full_rounds(NR);
    check("win_registraR_pulses", 16'(n_reg), 16'd10);
    check("win_contaE_pulses", 16'(n_ce), 16'd6);
    check("win_db", 16'(db_estado), 16'hA);
    check("win_flags", 16'({acertou, pronto, errou, timeout}), 16'b1100);
    check("win_rodada", 16'(rodada), 16'd3);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("win_persist", 16'({acertou, pronto, db_estado}), 16'h3A);

    // Wrong second play of round 2
    reset_dut();
    start_game();
    full_rounds(2);
    play(1'b1, 1'b0);
    settle();
    play(1'b0, 1'b0);
    check("erro_db", 16'(db_estado), 16'hE);
    check("erro_flags", 16'({errou, pronto, acertou, timeout}), 16'b1100);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
    check("erro_rodada_held", 16'(rodada), 16'd2);
    cycle(1, 0, 0, 0);
    check("erro_restart_db", 16'(db_estado), 16'h1);
    cycle(0, 0, 0, 0);
    check("erro_restart_rodada", 16'(rodada), 16'd0);

    // Timeout after exactly TO cycles in espera_jogada
    reset_dut();
    ten = 1'b1;
    start_game();
    count_to_timeout("timeout_cycles");
    check("timeout_db", 16'(db_estado), 16'hD);
    check("timeout_flags", 16'({timeout, pronto, acertou, errou}), 16'b1100);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
    check("timeout_persist", 16'(db_estado), 16'hD);

    // Timeout disabled: wait indefinitely
    ten = 1'b0;
    reset_dut();
    start_game();
    for (int k = 0; k < 100; k++) cycle(0, 0, 0, 0);
    check("no_timeout_db", 16'(db_estado), 16'h3);

    // Play arriving on the last timer cycle beats the timeout
    reset_dut();
    ten = 1'b1;
    start_game();
    for (int k = 0; k < TO - 1; k++) cycle(0, 0, 0, 0);
    check("edge_still_waiting", 16'(db_estado), 16'h3);
    cycle(0, 1, 0, 0);
    check("edge_play_taken", 16'(db_estado), 16'h4);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("edge_proximo", 16'(db_estado), 16'h6);
    cycle(0, 0, 0, 0);
    count_to_timeout("timer_cleared_cycles");
    check("edge_timeout_db", 16'(db_estado), 16'hD);
    ten = 1'b0;

    // Reset mid round 3 in comparacao; no effect before the edge
    reset_dut();
    start_game();
    full_rounds(3);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("midreset_pre_db", 16'(db_estado), 16'h5);
    rst = 1'b1;
    #2;
    check("midreset_between_edges", 16'({rodada, db_estado}), 16'h35);
    cycle(0, 0, 1, 1);
    check("midreset_db", 16'(db_estado), 16'h0);
    check("midreset_rodada", 16'(rodada), 16'd0);
    check("midreset_ctl", 16'({zeraE, zeraR, contaE, registraR, acertou, errou, timeout, pronto}),
          16'b11000000);
    rst = 1'b0;

    // Illegal state encoding recovers to inicial
    cycle(0, 0, 0, 0);
    force dut.estado = unidade_controle_rodadas_pkg::estado_t'(4'hB);
    #1;
    check("illegal_db", 16'(db_estado), 16'hF);
    release dut.estado;
    cycle(0, 0, 0, 0);
    check("illegal_recovered_db", 16'(db_estado), 16'h0);

    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
